// File: rtl/cpu_pkg.sv
// Shared CPU definitions.
// Widths, reset vector and the fetch-to-decode entry layout.
package cpu_pkg;

    localparam int XLEN = 32;
    localparam int INST_W = 32;
    localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;
    localparam int INST_BYTES = 4;

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer between fetch and decode.
// Registered head, no bypass; flush empties it in one cycle.
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter type entry_t = logic [63:0]
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         push,
    input  entry_t                       push_data,
    input  logic                         pop,
    output entry_t                       head,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty,
    output logic                         full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    entry_t         mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign do_push = push && !flush;
    assign do_pop  = pop && !flush;
    assign head    = mem[rd_ptr];
    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));

    // storage write; contents need no reset
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, credit-based issue, redirect flush.
// Responses from before a redirect are counted and dropped on arrival.
import cpu_pkg::*;

module fetch_unit #(
    parameter int                ADDR_W   = cpu_pkg::XLEN,
    parameter int                INST_W   = cpu_pkg::INST_W,
    parameter logic [ADDR_W-1:0] RESET_PC = cpu_pkg::RESET_PC,
    parameter int                DEPTH    = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_resp_valid,
    input  logic [INST_W-1:0] imem_resp_data,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst_data,
    output logic [ADDR_W-1:0] inst_pc
);

    localparam int CW = $clog2(DEPTH+1);
    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(INST_BYTES);

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } entry_t;

    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] resp_pc;
    logic [CW-1:0]     outstanding_cnt;
    logic [CW-1:0]     discard_cnt;
    logic [CW-1:0]     fifo_count;
    logic              fifo_empty;
    logic              fifo_full;
    entry_t            fifo_head;
    entry_t            push_entry;
    logic [CW:0]       inflight;
    logic              req_fire;
    logic              discarding;
    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] target;

    assign target   = {redirect_pc[ADDR_W-1:2], 2'b00};
    assign inflight = {1'b0, fifo_count} + {1'b0, outstanding_cnt};

    assign imem_req_valid = !reset && !redirect_valid
                         && (inflight < (CW+1)'(DEPTH));
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign discarding = (discard_cnt != '0);
    assign push       = imem_resp_valid && !discarding
                     && !redirect_valid && !fifo_full;
    assign push_entry = '{pc: resp_pc, inst: imem_resp_data};

    assign inst_valid = !reset && !redirect_valid && !fifo_empty;
    assign pop        = inst_valid && inst_ready;
    assign inst_data  = fifo_head.inst;
    assign inst_pc    = fifo_head.pc;

    // PCs, in-flight request count and stale-response count
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc        <= RESET_PC;
            resp_pc         <= RESET_PC;
            outstanding_cnt <= '0;
            discard_cnt     <= '0;
        end else if (redirect_valid) begin
            fetch_pc        <= target;
            resp_pc         <= target;
            outstanding_cnt <= outstanding_cnt - CW'(imem_resp_valid);
            discard_cnt     <= outstanding_cnt - CW'(imem_resp_valid);
        end else begin
            if (req_fire) begin
                fetch_pc <= fetch_pc + STEP;
            end
            outstanding_cnt <= outstanding_cnt + CW'(req_fire)
                             - CW'(imem_resp_valid);
            if (imem_resp_valid) begin
                if (discarding) begin
                    discard_cnt <= discard_cnt - CW'(1);
                end else begin
                    resp_pc <= resp_pc + STEP;
                end
            end
        end
    end

    fetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect_valid),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order memory model plus stream-level
// reference (sequential PCs from the last reset/redirect).
module tb_fetch_unit;

    localparam int DEPTH = 4;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;

    fetch_unit dut (
        .clk             (clk),
        .reset           (reset),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst_data       (inst_data),
        .inst_pc         (inst_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
        int          epoch;
    } mreq_t;

    mreq_t       mq[$];
    int          cyc;
    int          lat;
    int          epoch;
    int          occ;
    logic [31:0] exp_pc;
    logic [31:0] exp_fetch;
    int          n_cmp;
    int          n_bad;
    int          pops;
    int          acc;
    int          pop_idx;
    logic [31:0] first_pc;
    logic [31:0] second_pc;
    logic        last_iv;
    logic        last_rv;

    function automatic logic [31:0] mem_data(logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic mark();
        pop_idx   = 0;
        first_pc  = 32'hDEAD_BEEF;
        second_pc = 32'hDEAD_BEEF;
    endtask

    // one clock cycle: memory drive, checks, model update
    task automatic cycle();
        logic kept;
        logic exp_rv;
        logic exp_iv;
        int   outm;
        kept = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = $urandom;
        if (reset) begin
            mq.delete();
        end else if (mq.size() > 0 && mq[0].due == cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_data(mq[0].addr);
            kept = (mq[0].epoch == epoch) && !redirect_valid;
            void'(mq.pop_front());
        end
        outm   = mq.size() + (imem_resp_valid ? 1 : 0);
        exp_rv = !reset && !redirect_valid && (occ + outm < DEPTH);
        exp_iv = !reset && !redirect_valid && (occ > 0);
        @(negedge clk);
        last_iv = inst_valid;
        last_rv = imem_req_valid;
        chk("req_valid", {31'd0, imem_req_valid}, {31'd0, exp_rv});
        if (exp_rv) chk("req_addr", imem_req_addr, exp_fetch);
        chk("inst_valid", {31'd0, inst_valid}, {31'd0, exp_iv});
        if (exp_iv && inst_ready) begin
            chk("inst_pc", inst_pc, exp_pc);
            chk("inst_data", inst_data, mem_data(exp_pc));
            if (pop_idx == 0) first_pc = inst_pc;
            if (pop_idx == 1) second_pc = inst_pc;
            pop_idx++;
            exp_pc = exp_pc + 32'd4;
            occ--;
            pops++;
        end
        if (imem_req_valid && imem_req_ready) begin
            mq.push_back('{addr: imem_req_addr, due: cyc + lat,
                           epoch: epoch});
            exp_fetch = exp_fetch + 32'd4;
            acc++;
            chk("in_flight_bound", {31'd0, mq.size() <= DEPTH}, 32'd1);
        end
        if (kept) occ++;
        if (reset) begin
            occ = 0;
            exp_pc = RST_PC;
            exp_fetch = RST_PC;
            epoch++;
            mq.delete();
            mark();
        end else if (redirect_valid) begin
            occ = 0;
            exp_pc = redirect_pc & ~32'd3;
            exp_fetch = redirect_pc & ~32'd3;
            epoch++;
            mark();
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
    endtask

    task automatic set_lat(int l);
        logic save;
        save = imem_req_ready;
        imem_req_ready = 1'b0;
        run(4);
        lat = l;
        imem_req_ready = save;
    endtask

    initial begin
        logic        v1, v2, v3;
        logic        found;
        int          p0;
        int          a0;
        reset = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 32'd0;
        imem_req_ready = 1'b1;
        imem_resp_valid = 1'b0;
        imem_resp_data = 32'd0;
        inst_ready = 1'b1;
        cyc = 0; lat = 1; epoch = 0; occ = 0;
        exp_pc = RST_PC; exp_fetch = RST_PC;
        n_cmp = 0; n_bad = 0; pops = 0; acc = 0;
        mark();
        @(posedge clk);
        #1;

        // streaming, 1-cycle memory, first valid 3 cycles after reset
        do_reset();
        cycle(); v1 = last_iv;
        cycle(); v2 = last_iv;
        cycle(); v3 = last_iv;
        chk("first_valid_timing", {29'd0, v1, v2, v3}, 32'd1);
        p0 = pops;
        run(20);
        chk("stream_rate", {31'd0, (pops - p0) >= 19}, 32'd1);
        chk("stream_first_pc", first_pc, 32'h0);

        // decode stalled: only DEPTH requests, then drain in order
        inst_ready = 1'b0;
        do_reset();
        a0 = acc;
        run(10);
        chk("stall_accepts", acc - a0, DEPTH);
        chk("stall_req_idle", {31'd0, last_rv}, 32'd0);
        inst_ready = 1'b1;
        run(10);
        chk("drain_first", first_pc, 32'h0);
        chk("drain_second", second_pc, 32'h4);

        // ready toggling, 3-cycle latency, random decode stalls
        set_lat(3);
        p0 = pops;
        for (int i = 0; i < 120; i++) begin
            imem_req_ready = i[0];
            inst_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        imem_req_ready = 1'b1;
        inst_ready = 1'b1;
        chk("toggle_progress", {31'd0, (pops - p0) >= 25}, 32'd1);

        // redirect with 2 in flight and 2 buffered
        inst_ready = 1'b0;
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (occ == 2 && mq.size() == 2) found = 1'b1;
            else cycle();
        end
        chk("setup_2_2", {31'd0, found}, 32'd1);
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0100;
        cycle();
        redirect_valid = 1'b0;
        inst_ready = 1'b1;
        run(15);
        chk("redir_first", first_pc, 32'h100);
        chk("redir_second", second_pc, 32'h104);

        // redirect on a response cycle, then another one right after
        set_lat(2);
        run(8);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (mq.size() > 0 && mq[0].due == cyc) found = 1'b1;
            else cycle();
        end
        chk("setup_resp_cycle", {31'd0, found}, 32'd1);
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0200;
        cycle();
        redirect_pc = 32'h0000_0300;
        cycle();
        redirect_valid = 1'b0;
        run(15);
        chk("double_redir_first", first_pc, 32'h300);

        // wrap past the top of the address space, low bits ignored
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFE;
        cycle();
        redirect_valid = 1'b0;
        run(12);
        chk("wrap_first", first_pc, 32'hFFFF_FFFC);
        chk("wrap_second", second_pc, 32'h0000_0000);

        // reset in the middle of a stream
        set_lat(3);
        run(10);
        do_reset();
        run(12);
        chk("midreset_first", first_pc, RST_PC);
        chk("midreset_second", second_pc, RST_PC + 32'd4);

        // random mix of stalls, redirects and resets
        for (int blk = 0; blk < 5; blk++) begin
            set_lat($urandom_range(1, 3));
            for (int i = 0; i < 60; i++) begin
                imem_req_ready = ($urandom_range(0, 2) != 0);
                inst_ready = ($urandom_range(0, 3) != 0);
                redirect_pc = $urandom;
                redirect_valid = ($urandom_range(0, 15) == 0);
                reset = ($urandom_range(0, 59) == 0);
                cycle();
            end
            redirect_valid = 1'b0;
            reset = 1'b0;
        end
        imem_req_ready = 1'b1;
        inst_ready = 1'b1;
        p0 = pops;
        run(20);
        chk("final_progress", {31'd0, (pops - p0) >= 10}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
